// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared types and constants for the SHA-1 message padder
package sha1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    TAIL,
    MARK,
    ZERO,
    LENH,
    LENL
  } state_t;

  localparam logic [31:0] PAD_WORD        = 32'h8000_0000;
  localparam int          WORDS_PER_BLOCK = 16;
  localparam int          WIDX_W          = $clog2(WORDS_PER_BLOCK);

  typedef logic [WIDX_W-1:0] widx_t;

  localparam widx_t LEN_HI_IDX = widx_t'(14);
  localparam widx_t LEN_LO_IDX = widx_t'(15);

endpackage

// File: rtl/sha1_msg_padder_if.sv
// rtl/sha1_msg_padder_if.sv - message-in / padded-word-out handshake bundle
interface sha1_msg_padder_if;

  logic        start;
  logic [31:0] msg_len;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_last;
  logic        out_final;
  logic        busy;

  modport master (
    output start, msg_len, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_first, out_last, out_final, busy
  );

  modport slave (
    input  start, msg_len, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_first, out_last, out_final, busy
  );

endinterface

// File: rtl/sha1_tail_merge.sv
// rtl/sha1_tail_merge.sv - keeps the top r bytes of a word and appends the 0x80 marker
module sha1_tail_merge
  import sha1_pkg::*;
(
  input  logic [31:0] in_data,
  input  logic [1:0]  r,
  output logic [31:0] out_data
);

  always_comb begin
    out_data = PAD_WORD;
    case (r)
      2'd1:    out_data = {in_data[31:24], 8'h80, 16'h0000};
      2'd2:    out_data = {in_data[31:16], 8'h80, 8'h00};
      2'd3:    out_data = {in_data[31:8], 8'h80};
      default: out_data = PAD_WORD;
    endcase
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// rtl/sha1_msg_padder.sv - pads a byte-length message into 512-bit SHA-1 blocks, one word per transfer
module sha1_msg_padder
  import sha1_pkg::*;
(
  input logic              clk,
  input logic              reset_n,
  sha1_msg_padder_if.slave bus
);

  state_t      state, state_nxt;
  logic [31:0] rem, rem_nxt;
  logic [31:0] len_q, len_nxt;
  widx_t       widx, widx_nxt;

  logic [31:0] tail_word;
  logic [31:0] rem_dec;
  logic [31:0] out_data;
  logic        out_valid;
  logic        in_ready;
  logic        xfer;
  state_t      after_marker;

  sha1_tail_merge u_tail_merge (
    .in_data  (bus.in_data),
    .r        (rem[1:0]),
    .out_data (tail_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rem   <= '0;
      len_q <= '0;
      widx  <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      len_q <= len_nxt;
      widx  <= widx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    len_nxt   = len_q;
    widx_nxt  = widx;
    out_data  = '0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    rem_dec   = rem - 32'd4;
    // A marker word landing on widx 13 leaves no zero fill before the length.
    after_marker = (widx == LEN_HI_IDX - widx_t'(1)) ? LENH : ZERO;

    case (state)
      DATA: begin
        out_data  = bus.in_data;
        out_valid = bus.in_valid;
        in_ready  = bus.out_ready;
      end
      TAIL: begin
        out_data  = tail_word;
        out_valid = bus.in_valid;
        in_ready  = bus.out_ready;
      end
      MARK: begin
        out_data  = PAD_WORD;
        out_valid = 1'b1;
      end
      ZERO: out_valid = 1'b1;
      LENH: begin
        out_data  = {29'b0, len_q[31:29]};
        out_valid = 1'b1;
      end
      LENL: begin
        out_data  = {len_q[28:0], 3'b000};
        out_valid = 1'b1;
      end
      default: ;
    endcase

    xfer = out_valid && bus.out_ready;
    if (xfer) widx_nxt = widx + widx_t'(1);

    case (state)
      IDLE: begin
        if (bus.start) begin
          len_nxt  = bus.msg_len;
          rem_nxt  = bus.msg_len;
          widx_nxt = '0;
          if (bus.msg_len >= 32'd4)      state_nxt = DATA;
          else if (bus.msg_len != 32'd0) state_nxt = TAIL;
          else                           state_nxt = MARK;
        end
      end
      DATA: begin
        if (xfer) begin
          rem_nxt = rem_dec;
          if (rem_dec < 32'd4) state_nxt = (rem_dec != 32'd0) ? TAIL : MARK;
        end
      end
      TAIL: begin
        if (xfer) begin
          rem_nxt   = '0;
          state_nxt = after_marker;
        end
      end
      MARK: if (xfer) state_nxt = after_marker;
      ZERO: if (xfer && widx == LEN_HI_IDX - widx_t'(1)) state_nxt = LENH;
      LENH: if (xfer) state_nxt = LENL;
      LENL: if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready;
  assign bus.out_first = out_valid && (widx == '0);
  assign bus.out_last  = out_valid && (widx == LEN_LO_IDX);
  assign bus.out_final = out_valid && (widx == LEN_LO_IDX) && (state == LENL);
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sha1_msg_padder.sv
// tb/tb_sha1_msg_padder.sv - directed self-checking bench for sha1_msg_padder
module tb_sha1_msg_padder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sha1_msg_padder_if bus();

  sha1_msg_padder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int passed = 0;

  logic [7:0]  msg [0:127];
  logic [31:0] got_d [$];
  logic        got_f [$];
  logic        got_l [$];
  logic        got_z [$];
  int          inr_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"},  bus.out_data,       32'd0);
    chk({tag, "_out_first"}, 32'(bus.out_first), 32'd0);
    chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_out_final"}, 32'(bus.out_final), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  function automatic logic [31:0] word_of(input int wi, input int len, input logic [7:0] fill);
    logic [31:0] w;
    w = 32'h5A5A_5A5A;
    if (4 * wi < len) begin
      for (int b = 0; b < 4; b++)
        w[31-8*b -: 8] = (4 * wi + b < len) ? msg[4*wi+b] : fill;
    end
    return w;
  endfunction

  function automatic logic [31:0] gw(input int k);
    return (k < got_d.size()) ? got_d[k] : 32'hDEAD_BEEF;
  endfunction

  task automatic run_msg(input int len, input bit stall, input bit mid_start,
                         input int abort_at, input logic [7:0] fill);
    int          nwords;
    int          exp_n;
    int          total;
    int          wi;
    int          cyc;
    int          j;
    bit          done;
    bit          prev_stall;
    logic [31:0] prev_d;
    logic [2:0]  prev_fl;
    logic [63:0] bitlen;
    logic [31:0] expw;
    logic [7:0]  bb;
    nwords     = (len + 3) / 4;
    exp_n      = 16 * ((len + 9 + 63) / 64);
    total      = exp_n * 4;
    bitlen     = 64'(len) * 64'd8;
    wi         = 0;
    cyc        = 0;
    done       = 1'b0;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_fl    = '0;
    inr_cycles = 0;
    got_d.delete(); got_f.delete(); got_l.delete(); got_z.delete();

    @(negedge clk);
    bus.start   = 1'b1;
    bus.msg_len = 32'(len);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      bus.start     = mid_start && (cyc == 9);
      bus.msg_len   = 32'd5;
      bus.in_valid  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data   = word_of(wi, len, fill);
      #1;
      if (cyc == 0) chk("busy_after_start", 32'(bus.busy), 32'd1);
      if (abort_at >= 0 && got_d.size() == abort_at && bus.out_valid) begin
        bus.start = 1'b0;
        reset_n   = 1'b0;
        #1;
        outputs_zero("reset_mid");
        @(negedge clk);
        #1;
        outputs_zero("reset_hold");
        reset_n = 1'b1;
        return;
      end
      if (prev_stall && bus.out_valid) begin
        chk("hold_data", bus.out_data, prev_d);
        chk("hold_flags", 32'({bus.out_first, bus.out_last, bus.out_final}), 32'(prev_fl));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d     = bus.out_data;
      prev_fl    = {bus.out_first, bus.out_last, bus.out_final};
      if (bus.in_ready) inr_cycles++;
      if (bus.in_valid && bus.in_ready) wi++;
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(bus.out_data);
        got_f.push_back(bus.out_first);
        got_l.push_back(bus.out_last);
        got_z.push_back(bus.out_final);
        if (bus.out_final) done = 1'b1;
      end
      cyc++;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;

    chk("msg_done", 32'(done), 32'd1);
    chk("word_count", got_d.size(), exp_n);
    chk("words_consumed", wi, nwords);
    for (int k = 0; k < exp_n && k < got_d.size(); k++) begin
      for (int b = 0; b < 4; b++) begin
        j = 4 * k + b;
        if (j < len)             bb = msg[j];
        else if (j == len)       bb = 8'h80;
        else if (j >= total - 8) bb = bitlen[8*(total-1-j) +: 8];
        else                     bb = 8'h00;
        expw[31-8*b -: 8] = bb;
      end
      chk($sformatf("len%0d_w%0d", len, k), got_d[k], expw);
      chk($sformatf("len%0d_flags%0d", len, k),
          32'({got_f[k], got_l[k], got_z[k]}),
          32'({(k % 16) == 0, (k % 16) == 15, k == exp_n - 1}));
    end
    @(negedge clk);
    #1;
    chk("busy_after_final", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.msg_len   = 32'd0;
    bus.in_data   = 32'h1234_5678;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Empty message: marker then length only, no input consumed.
    run_msg(0, 1'b0, 1'b0, -1, 8'h00);
    chk("len0_w0", gw(0), 32'h8000_0000);
    chk("len0_w15", gw(15), 32'h0000_0000);
    chk("len0_no_in_ready", 32'(inr_cycles), 32'd0);

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 1'b0, 1'b0, -1, 8'h00);
    chk("abc_w0", gw(0), 32'h6162_6380);
    chk("abc_w15", gw(15), 32'h0000_0018);
    chk("abc_first", 32'(got_f.size() > 0 && got_f[0]), 32'd1);

    for (int i = 0; i < 128; i++) msg[i] = 8'((i * 7 + 3) & 255);
    run_msg(55, 1'b0, 1'b0, -1, 8'h5A);
    chk("len55_w13", gw(13), 32'h6F76_7D80);
    chk("len55_w14", gw(14), 32'h0000_0000);
    chk("len55_w15", gw(15), 32'h0000_01B8);

    run_msg(56, 1'b0, 1'b0, -1, 8'h5A);
    chk("len56_w14", gw(14), 32'h8000_0000);
    chk("len56_w15", gw(15), 32'h0000_0000);
    chk("len56_last15", 32'(got_l.size() > 15 && got_l[15]), 32'd1);
    chk("len56_final15", 32'(got_z.size() > 15 && got_z[15]), 32'd0);
    chk("len56_w31", gw(31), 32'h0000_01C0);

    // Random stalls on both sides plus a stray start pulse mid-message.
    run_msg(64, 1'b1, 1'b1, -1, 8'h5A);
    chk("len64_w16", gw(16), 32'h8000_0000);
    chk("len64_w31", gw(31), 32'h0000_0200);

    run_msg(64, 1'b0, 1'b0, 7, 8'h5A);
    @(negedge clk);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 1'b0, 1'b0, -1, 8'h00);
    chk("post_reset_abc_w0", gw(0), 32'h6162_6380);
    chk("post_reset_abc_w15", gw(15), 32'h0000_0018);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sha1_msg_padder.md
# sha1_msg_padder

Streaming front end for the SHA-1 compression core. It accepts a byte-length-announced message as big-endian 32-bit words and emits the padded message as a stream of 512-bit blocks, one 32-bit word per transfer, in the same order the core's W[0..15] schedule consumes them. It appends the 0x80 marker, the zero fill, and the 64-bit bit-length per FIPS 180-4. It sits between the message source (host or DMA) and the SHA-1 round engine.

## Interface
- No parameters. Message length is fixed at 32 bits (bytes). Bit length is formed in 64 bits.
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that latches msg_len and begins a message; honoured only when busy=0
- msg_len  in  32  message length in bytes
- in_data  in  32  message word, big-endian; the final partial word is left-justified (upper bytes valid)
- in_valid  in  1  in_data valid
- in_ready  out  1  padder accepts in_data this cycle
- out_data  out  32  padded message word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_first  out  1  out_data is word 0 of a block
- out_last  out  1  out_data is word 15 of a block
- out_final  out  1  out_data is word 15 of the final block
- busy  out  1  message in progress (start through final-word transfer)

## Operation
- Transfer rule: a word moves on any cycle with out_valid&&out_ready. widx (0..15) increments on each transfer and wraps 15→0.
- Input rule: a word is consumed on in_valid&&in_ready. The input is never consumed without a matching output transfer.
- Counters: rem = bytes not yet consumed, loaded with msg_len on start. widx is cleared on start.
- States:
  - IDLE: accepts start.
    - To DATA if msg_len≥4.
    - To TAIL if 1≤msg_len≤3.
    - To MARK if msg_len=0.
  - DATA: pass-through. out_data=in_data, out_valid=in_valid, in_ready=out_ready. rem decrements by 4 per transfer. Exits when rem reaches <4:
    - To TAIL if rem≠0.
    - To MARK if rem=0.
  - TAIL: consumes one input word. out_data keeps the top r=rem bytes of in_data, ORs in 0x80 at byte position r, and zeroes the remaining bytes. Example: r=1 gives {in[31:24],8'h80,16'h0}.
  - MARK: emits 32'h80000000 with no input. out_valid=1 and in_ready=0.
  - ZERO: emits 0 until the transferred word has widx=13, then goes to LENH. If the marker word landed at widx 14 or 15, ZERO runs through widx 15 and on through widx 13 of the next block.
  - LENH: emits {29'b0,msg_len[31:29]}.
  - LENL: emits {msg_len[28:0],3'b0}, with out_final=1. On transfer, returns to IDLE and busy=0.
  - After TAIL or MARK, the next state is ZERO. It is LENH directly if the marker was at widx 13.
- Word count: 16×ceil((msg_len+9)/64) words are emitted per message.
- Flags:
  - out_first = out_valid && widx==0.
  - out_last = out_valid && widx==15.
  - out_final = out_last in LENL.
- Ignored inputs:
  - start while busy=1 is ignored and has no effect on the message in flight.
  - in_valid outside DATA/TAIL is ignored (in_ready=0).
- Reset (at any time, including mid-block): state=IDLE, rem=0, widx=0. All outputs are 0: in_ready, out_valid, out_data, out_first, out_last, out_final, busy. No partial block is completed after reset.

## Timing
- start is sampled on the rising edge, and busy=1 the following cycle.
- The first out_valid comes the cycle after start:
  - in DATA/TAIL, gated by in_valid;
  - in MARK, unconditional.
- DATA/TAIL have zero latency (combinational pass-through and merge). Upstream must hold in_data while in_valid&&!in_ready.
- MARK/ZERO/LENH/LENL drive registered-state outputs. out_data and flags stay stable while out_valid&&!out_ready.
- Throughput is one word per cycle when in_valid and out_ready are both held high.
- The LENL transfer edge returns to IDLE. A new start is accepted on the next cycle, so the minimum gap between messages is 1 idle cycle.

## Structure
- sha1_pkg holds:
  - state enum (IDLE, DATA, TAIL, MARK, ZERO, LENH, LENL);
  - PAD_WORD=32'h80000000;
  - WORDS_PER_BLOCK=16;
  - LEN_HI_IDX=14;
  - LEN_LO_IDX=15.
- One combinational sub-module, sha1_tail_merge (in_data, r[1:0] → padded word), is used only by TAIL.
- The FSM, rem and widx live in the top module.

## Test plan
- msg_len=0, out_ready=1 → 16 words: word0=0x80000000, words1–14=0, word15=0x00000000. out_final asserts on word15. No in_ready pulses.
- msg_len=3, in_data=0x61626300 ("abc") → word0=0x61626380, words1–14=0, word15=0x00000018. One block; out_first on word0.
- msg_len=55, 14 input words → word13 = top 3 bytes | 0x80 in the low byte, word14=0, word15=0x000001B8. Exactly 16 words.
- msg_len=56, 14 input words → block1: word14=0x80000000, word15=0 with out_last=1, out_final=0. Block2: words0–13=0, word14=0, word15=0x000001C0, with out_final=1. 32 words total.
- msg_len=64 with random in_valid and out_ready stalls → output sequence identical to the no-stall run. out_data and flags held during each stall. 32 words, final word 0x00000200. A start pulse mid-message is ignored.
- Assert reset_n low at widx=7 of the msg_len=64 case → all outputs 0 during reset. After release, a fresh start with msg_len=3 produces the "abc" block exactly.
